rtc_time_core: RTL and testbench
================================

# rtc_time_core

Parametrised time-of-day counter that replaces the separate seconds/minutes/hours blocks of the real-time clock with one cascaded core. It advances on the one-cycle `tc_time_base` strobe from the time-base divider, accepts per-field register loads over the existing 6-bit load bus, and emits carry pulses for downstream calendar logic. It also provides a 12/24-hour display view and an optional alarm comparator.

## Interface
- `HOUR_MOD`, default 24: hours per day, legal range 2..32. Hours wrap from HOUR_MOD-1 to 0.
- `HW`, default 5: hour field width. Must satisfy 2^HW >= HOUR_MOD. Not checked in RTL.
- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-high.
- `tc_time_base` in 1: one-second strobe, one cycle wide.
- `hold` in 1: when 1, ticks are ignored; loads still act.
- `load` in 1: write strobe.
- `addrs` in 3: field select. 000 seconds, 001 minutes, 010 hours, 011 control, 100 alarm minutes, 101 alarm hours; 110 and 111 are unused.
- `data_in` in 6: write data.
- `alarm_ack` in 1: clears `alarm`.
- `q_seconds` out 6: seconds, 0..59.
- `q_minutes` out 6: minutes, 0..59.
- `q_hours` out HW: raw hours, 0..HOUR_MOD-1.
- `disp_hours` out HW: display hours, 12h or 24h form.
- `pm` out 1: high when `q_hours` >= 12 in 12h mode; 0 in 24h mode.
- `tc_minute`, `tc_hour`, `tc_day` out 1 each: one-cycle carry pulses.
- `load_err` out 1: one-cycle pulse on a rejected load.
- `alarm` out 1: sticky alarm flag.

## Operation
- Priority on each clock edge: reset > load > tick.
- Reset:
  - Clears all fields, the mode bit, both alarm registers, and all pulses.
  - `alarm` resets to 0.
  - `disp_hours` resets to 0 (24h mode at reset).
- Load (`load`=1):
  - Writes the addressed field at the next edge.
  - Counting is suppressed in that cycle. A coincident tick is dropped and no carry pulses fire.
  - Seconds and minutes take `data_in`. A value > 59 is rejected: field unchanged, `load_err`=1 for one cycle.
  - Hours take `data_in[HW-1:0]`. Rejected if `data_in` >= HOUR_MOD.
  - Control: `data_in[0]` is the mode bit (1 = 12h). Bits 5:1 are ignored. A control write also clears `alarm`.
  - Addresses 110 and 111 are ignored without error.
- Tick (`tc_time_base`=1, `hold`=0, `load`=0):
  - Seconds increment. 59 wraps to 0.
  - On the seconds wrap, minutes increment. 59 wraps to 0.
  - On the minutes wrap, hours increment. HOUR_MOD-1 wraps to 0.
- Carry pulses are registered:
  - `tc_minute` is high in the cycle where `q_seconds` first reads 0 after a wrap.
  - `tc_hour` additionally requires the minutes wrap.
  - `tc_day` additionally requires the hours wrap.
- Display (combinational from registers):
  - 24h mode: `disp_hours` = `q_hours`, `pm`=0.
  - 12h mode, valid only when HOUR_MOD=24: 0→12, 1..12 unchanged, 13..23→1..11. `pm` = (`q_hours` >= 12).
  - If HOUR_MOD≠24, the mode bit has no effect.
- Arithmetic is unsigned. Only the next-state values are compared; there are no free-running wider counters.

## Timing
- Every output is registered except `disp_hours` and `pm`.
- Latency: one cycle from a tick or load edge to the new field value.
- Pulses are exactly one cycle wide. Back-to-back ticks on consecutive cycles are legal and each one counts.
- `alarm` sets in the same cycle its triggering tick takes effect.
- `alarm` clears one cycle after `alarm_ack`. If set and ack coincide, set wins.
- Reset asserted mid-operation clears everything at that edge. The first tick after reset deassertion counts.

## Configuration
- With `RTC_ALARM_EN` defined:
  - Alarm-minute and alarm-hour registers load via addresses 100 and 101, with the same range checks and `load_err` behaviour.
  - `alarm` sets when a tick moves the time to alarm-hour:alarm-minute:00.
  - A load landing directly on that time does not set `alarm`.
- Without `RTC_ALARM_EN`:
  - No alarm registers are built.
  - Addresses 100 and 101 are ignored with no `load_err`.
  - `alarm` is tied to 0 and `alarm_ack` is unused.

## Test plan
- Reset, then 60 ticks → `q_seconds`=0, `q_minutes`=1. `tc_minute` pulses once, in the cycle where seconds read 0.
- Load 23:59:58, then 2 ticks → time 00:00:00. `tc_minute`, `tc_hour`, and `tc_day` each pulse once, in the same cycle.
- Load minutes with 60 → `q_minutes` unchanged, `load_err` high for one cycle. Load hours with 24 at HOUR_MOD=24 → rejected the same way.
- Load and tick in the same cycle with addrs=000, data 10 → `q_seconds`=10, tick dropped. With `hold`=1, 5 ticks → no change.
- 12h mode via control write 1: hours 0 → `disp_hours`=12, `pm`=0. Hours 13 → 1, `pm`=1. Hours 12 → 12, `pm`=1.
- With `RTC_ALARM_EN`: alarm set to 07:30, time loaded to 07:29:59, one tick → `alarm`=1. `alarm_ack` → 0 next cycle. Without the macro, the same sequence leaves `alarm`=0.

Source files
------------

// File: rtl/rtc_time_core.sv
// rtc_time_core
//   Cascaded seconds/minutes/hours time-of-day counter for the RTC.
//   Advances on the one-cycle tc_time_base strobe. Accepts per-field
//   loads on the 6-bit load bus. Emits registered carry pulses for the
//   calendar logic. Provides a 12/24h display view.
//
//   Optional feature: define RTC_ALARM_EN to build the alarm
//   registers (addresses 100/101) and the alarm comparator. Without it,
//   alarm is tied low and alarm_ack is unused.
//
// Parameters
//   HOUR_MOD : hours per day, 2..32 (hours wrap HOUR_MOD-1 -> 0)
//   HW       : hour field width, 2^HW >= HOUR_MOD
// Ports
//   clk, reset        : clock, synchronous active-high reset
//   tc_time_base      : one-second strobe
//   hold              : ignore ticks (loads still act)
//   load/addrs/data_in: field write (0 sec, 1 min, 2 hour, 3 ctrl,
//                       4 alarm min, 5 alarm hour)
//   alarm_ack         : clears alarm
//   q_seconds/q_minutes/q_hours : raw time
//   disp_hours, pm    : display view (combinational)
//   tc_minute/tc_hour/tc_day    : carry pulses
//   load_err          : pulse on a rejected load
//   alarm             : sticky alarm flag
module rtc_time_core #(
  parameter int HOUR_MOD = 24,
  parameter int HW       = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          tc_time_base,
  input  logic          hold,
  input  logic          load,
  input  logic [2:0]    addrs,
  input  logic [5:0]    data_in,
  input  logic          alarm_ack,
  output logic [5:0]    q_seconds,
  output logic [5:0]    q_minutes,
  output logic [HW-1:0] q_hours,
  output logic [HW-1:0] disp_hours,
  output logic          pm,
  output logic          tc_minute,
  output logic          tc_hour,
  output logic          tc_day,
  output logic          load_err,
  output logic          alarm
);

  localparam logic [5:0]    SM_MAX    = 6'd59;
  localparam logic [5:0]    HOUR_LIM  = 6'(HOUR_MOD - 1);
  localparam logic [HW-1:0] HOUR_LAST = HW'(HOUR_MOD - 1);
  localparam logic [HW-1:0] H12       = HW'(12);
  localparam bit            MODE12_OK = (HOUR_MOD == 24);

  logic [5:0]    r_sec, r_min;
  logic [HW-1:0] r_hour;
  logic          r_mode;
  logic          r_tc_min, r_tc_hour, r_tc_day, r_load_err;

  logic          w_tick;
  logic          w_sec_wrap, w_min_wrap, w_hour_wrap;
  logic [5:0]    w_sec_next, w_min_next;
  logic [HW-1:0] w_hour_next;
  logic          w_bad_sm, w_bad_h;
  logic          w_load_err;
  logic          w_ctrl_wr;

  // Loads take the cycle: a coincident tick is dropped, no carries fire.
  assign w_tick      = tc_time_base & ~hold & ~load;

  assign w_sec_wrap  = (r_sec == SM_MAX);
  assign w_min_wrap  = w_sec_wrap & (r_min == SM_MAX);
  assign w_hour_wrap = w_min_wrap & (r_hour == HOUR_LAST);

  assign w_sec_next  = w_sec_wrap  ? 6'd0 : r_sec + 6'd1;
  assign w_min_next  = w_min_wrap  ? 6'd0 : (w_sec_wrap ? r_min + 6'd1 : r_min);
  assign w_hour_next = w_hour_wrap ? '0   : (w_min_wrap ? r_hour + HW'(1) : r_hour);

  // Range checks use the full 6-bit bus so upper bits cannot alias.
  assign w_bad_sm    = (data_in > SM_MAX);
  assign w_bad_h     = (data_in > HOUR_LIM);
  assign w_ctrl_wr   = load & (addrs == 3'b011);

  always_comb begin
    w_load_err = 1'b0;
    if (load) begin
      case (addrs)
        3'b000, 3'b001: w_load_err = w_bad_sm;
        3'b010:         w_load_err = w_bad_h;
`ifdef RTC_ALARM_EN
        3'b100:         w_load_err = w_bad_sm;
        3'b101:         w_load_err = w_bad_h;
`endif
        default:        w_load_err = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sec      <= '0;
      r_min      <= '0;
      r_hour     <= '0;
      r_mode     <= 1'b0;
      r_tc_min   <= 1'b0;
      r_tc_hour  <= 1'b0;
      r_tc_day   <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      r_tc_min   <= w_tick & w_sec_wrap;
      r_tc_hour  <= w_tick & w_min_wrap;
      r_tc_day   <= w_tick & w_hour_wrap;
      r_load_err <= w_load_err;
      if (load) begin
        case (addrs)
          3'b000:  if (!w_bad_sm) r_sec  <= data_in;
          3'b001:  if (!w_bad_sm) r_min  <= data_in;
          3'b010:  if (!w_bad_h)  r_hour <= data_in[HW-1:0];
          3'b011:  r_mode <= data_in[0];
          default: ;
        endcase
      end else if (w_tick) begin
        r_sec  <= w_sec_next;
        r_min  <= w_min_next;
        r_hour <= w_hour_next;
      end
    end
  end

`ifdef RTC_ALARM_EN
  logic [5:0]    r_alm_min;
  logic [HW-1:0] r_alm_hour;
  logic          r_alarm;
  logic          w_alarm_hit;

  // Compare against the next-state time so the flag rises together with
  // the tick that reaches hh:mm:00. Loads never pass w_tick, so a load
  // onto the alarm time cannot fire it.
  assign w_alarm_hit = w_tick & w_sec_wrap & (w_min_next == r_alm_min) &
                       (w_hour_next == r_alm_hour);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_alm_min  <= '0;
      r_alm_hour <= '0;
      r_alarm    <= 1'b0;
    end else begin
      if (load && addrs == 3'b100 && !w_bad_sm) r_alm_min  <= data_in;
      if (load && addrs == 3'b101 && !w_bad_h)  r_alm_hour <= data_in[HW-1:0];
      // Set wins over ack / control-write clear.
      if (w_alarm_hit)                r_alarm <= 1'b1;
      else if (alarm_ack || w_ctrl_wr) r_alarm <= 1'b0;
    end
  end

  assign alarm = r_alarm;
`else
  logic w_unused;
  assign w_unused = alarm_ack ^ w_ctrl_wr;
  assign alarm    = 1'b0;
`endif

  // 12h view only makes sense for a 24-hour day.
  always_comb begin
    disp_hours = r_hour;
    pm         = 1'b0;
    if (MODE12_OK && r_mode) begin
      pm = (r_hour >= H12);
      if (r_hour == '0)      disp_hours = H12;
      else if (r_hour > H12) disp_hours = r_hour - H12;
    end
  end

  assign q_seconds = r_sec;
  assign q_minutes = r_min;
  assign q_hours   = r_hour;
  assign tc_minute = r_tc_min;
  assign tc_hour   = r_tc_hour;
  assign tc_day    = r_tc_day;
  assign load_err  = r_load_err;

endmodule

// File: tb/tb_rtc_time_core.sv
module tb_rtc_time_core;

  logic       clk, reset, tc_time_base, hold, load, alarm_ack;
  logic [2:0] addrs;
  logic [5:0] data_in;
  logic [5:0] q_seconds, q_minutes;
  logic [4:0] q_hours, disp_hours;
  logic       pm, tc_minute, tc_hour, tc_day, load_err, alarm;

  rtc_time_core #(.HOUR_MOD(24), .HW(5)) dut (
    .clk(clk), .reset(reset), .tc_time_base(tc_time_base), .hold(hold),
    .load(load), .addrs(addrs), .data_in(data_in), .alarm_ack(alarm_ack),
    .q_seconds(q_seconds), .q_minutes(q_minutes), .q_hours(q_hours),
    .disp_hours(disp_hours), .pm(pm), .tc_minute(tc_minute),
    .tc_hour(tc_hour), .tc_day(tc_day), .load_err(load_err), .alarm(alarm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef RTC_ALARM_EN
  localparam bit ALM = 1'b1;
`else
  localparam bit ALM = 1'b0;
`endif

  typedef struct packed {
    logic [5:0] s;
    logic [5:0] m;
    logic [4:0] h;
    logic tcm, tch, tcd, lerr, alm;
  } snap_t;

  snap_t exp_q[$];
  int total = 0;
  int bad   = 0;

  // Reference time-of-day model
  int ms, mm, mh, am, ah;
  bit mmode, malarm;

  function automatic snap_t mk(bit tcm, bit tch, bit tcd, bit lerr);
    snap_t e;
    e.s = 6'(ms); e.m = 6'(mm); e.h = 5'(mh);
    e.tcm = tcm; e.tch = tch; e.tcd = tcd; e.lerr = lerr; e.alm = malarm;
    return e;
  endfunction

  function automatic snap_t mdl_reset();
    ms = 0; mm = 0; mh = 0; am = 0; ah = 0; mmode = 0; malarm = 0;
    return mk(0, 0, 0, 0);
  endfunction

  function automatic snap_t mdl_idle(bit ack);
    if (ack) malarm = 0;
    return mk(0, 0, 0, 0);
  endfunction

  function automatic snap_t mdl_tick(bit ack);
    bit cm, ch, cd;
    cm = 0; ch = 0; cd = 0;
    if (ack) malarm = 0;
    ms++;
    if (ms == 60) begin
      ms = 0; cm = 1; mm++;
      if (mm == 60) begin
        mm = 0; ch = 1; mh++;
        if (mh == 24) begin mh = 0; cd = 1; end
      end
    end
    if (ALM && cm && mm == am && mh == ah) malarm = 1;
    return mk(cm, ch, cd, 0);
  endfunction

  function automatic snap_t mdl_load(int a, int d, bit ack);
    bit err;
    err = 0;
    if (ack) malarm = 0;
    case (a)
      0: if (d > 59) err = 1; else ms = d;
      1: if (d > 59) err = 1; else mm = d;
      2: if (d >= 24) err = 1; else mh = d;
      3: begin mmode = d[0]; malarm = 0; end
      4: if (ALM) begin if (d > 59) err = 1; else am = d; end
      5: if (ALM) begin if (d >= 24) err = 1; else ah = d; end
      default: ;
    endcase
    return mk(0, 0, 0, err);
  endfunction

  function automatic snap_t observe();
    snap_t a;
    a.s = q_seconds; a.m = q_minutes; a.h = q_hours;
    a.tcm = tc_minute; a.tch = tc_hour; a.tcd = tc_day;
    a.lerr = load_err; a.alm = alarm;
    return a;
  endfunction

  function automatic string fmt(snap_t x);
    return $sformatf("%0d:%0d:%0d tc=%b%b%b err=%b alarm=%b",
                     x.h, x.m, x.s, x.tcm, x.tch, x.tcd, x.lerr, x.alm);
  endfunction

  // Drive one cycle of stimulus; the expected outcome goes on the queue.
  task automatic drive(input bit rst, input bit tk, input bit hd, input bit ld,
                       input int a, input int d, input bit ack);
    reset = rst; tc_time_base = tk; hold = hd; load = ld;
    addrs = 3'(a); data_in = 6'(d); alarm_ack = ack;
    if (rst)           exp_q.push_back(mdl_reset());
    else if (ld)       exp_q.push_back(mdl_load(a, d, ack));
    else if (tk && !hd) exp_q.push_back(mdl_tick(ack));
    else               exp_q.push_back(mdl_idle(ack));
    @(posedge clk); #1;
    reset = 0; tc_time_base = 0; hold = 0; load = 0;
    addrs = 0; data_in = 0; alarm_ack = 0;
  endtask

  task automatic test_reset();
    snap_t e, a;
    drive(1, 1, 0, 1, 0, 33, 0);
    e = exp_q.pop_front(); a = observe(); total++;
    if (a !== e) begin bad++; $display("FAIL reset_state: got %s want %s", fmt(a), fmt(e)); end
    total++;
    if ({disp_hours, pm} !== 6'd0) begin
      bad++; $display("FAIL reset_disp: got disp=%0d pm=%b want disp=0 pm=0", disp_hours, pm);
    end
  endtask

  task automatic test_minute();
    snap_t e, a;
    int n_tcm = 0;
    for (int i = 0; i < 60; i++) begin
      drive(0, 1, 0, 0, 0, 0, 0);
      e = exp_q.pop_front(); a = observe(); total++;
      if (a.tcm === 1'b1) n_tcm++;
      if (a !== e) begin bad++; $display("FAIL minute_tick%0d: got %s want %s", i, fmt(a), fmt(e)); end
    end
    total++;
    if (n_tcm != 1) begin bad++; $display("FAIL minute_pulse_count: got %0d want 1", n_tcm); end
  endtask

  task automatic test_midnight();
    snap_t e, a;
    int tbl[5][2] = '{'{2, 23}, '{1, 59}, '{0, 58}, '{-1, 0}, '{-1, 0}};
    for (int i = 0; i < 5; i++) begin
      if (tbl[i][0] >= 0) drive(0, 0, 0, 1, tbl[i][0], tbl[i][1], 0);
      else                drive(0, 1, 0, 0, 0, 0, 0);
      e = exp_q.pop_front(); a = observe(); total++;
      if (a !== e) begin bad++; $display("FAIL midnight_step%0d: got %s want %s", i, fmt(a), fmt(e)); end
    end
    drive(0, 0, 0, 0, 0, 0, 1);
    e = exp_q.pop_front(); a = observe(); total++;
    if (a !== e) begin bad++; $display("FAIL midnight_after: got %s want %s", fmt(a), fmt(e)); end
  endtask

  task automatic test_load_err();
    snap_t e, a;
    int tbl[6][2] = '{'{1, 60}, '{-1, 0}, '{2, 24}, '{2, 23}, '{0, 63}, '{6, 5}};
    for (int i = 0; i < 6; i++) begin
      if (tbl[i][0] >= 0) drive(0, 0, 0, 1, tbl[i][0], tbl[i][1], 0);
      else                drive(0, 0, 0, 0, 0, 0, 0);
      e = exp_q.pop_front(); a = observe(); total++;
      if (a !== e) begin bad++; $display("FAIL load_err_step%0d: got %s want %s", i, fmt(a), fmt(e)); end
    end
  endtask

  task automatic test_load_tick_hold();
    snap_t e, a;
    drive(0, 1, 0, 1, 0, 10, 0);
    e = exp_q.pop_front(); a = observe(); total++;
    if (a !== e) begin bad++; $display("FAIL load_beats_tick: got %s want %s", fmt(a), fmt(e)); end
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, 1, 0, 0, 0, 0);
      e = exp_q.pop_front(); a = observe(); total++;
      if (a !== e) begin bad++; $display("FAIL hold_tick%0d: got %s want %s", i, fmt(a), fmt(e)); end
    end
  endtask

  task automatic test_back_to_back();
    snap_t e, a;
    drive(0, 0, 0, 1, 0, 57, 0);
    void'(exp_q.pop_front());
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, 0, 0, 0, 0, 0);
      e = exp_q.pop_front(); a = observe(); total++;
      if (a !== e) begin bad++; $display("FAIL b2b_tick%0d: got %s want %s", i, fmt(a), fmt(e)); end
    end
  endtask

  task automatic test_12h();
    snap_t e, a;
    int tbl[6][3] = '{'{0, 12, 0}, '{13, 1, 1}, '{12, 12, 1},
                      '{23, 11, 1}, '{1, 1, 0}, '{11, 11, 0}};
    drive(0, 0, 0, 1, 3, 1, 0);
    e = exp_q.pop_front(); a = observe(); total++;
    if (a !== e) begin bad++; $display("FAIL mode12_write: got %s want %s", fmt(a), fmt(e)); end
    for (int i = 0; i < 6; i++) begin
      drive(0, 0, 0, 1, 2, tbl[i][0], 0);
      void'(exp_q.pop_front());
      total++;
      if (disp_hours !== 5'(tbl[i][1]) || pm !== 1'(tbl[i][2])) begin
        bad++; $display("FAIL disp12_h%0d: got disp=%0d pm=%b want disp=%0d pm=%0d",
                        tbl[i][0], disp_hours, pm, tbl[i][1], tbl[i][2]);
      end
    end
    drive(0, 0, 0, 1, 3, 0, 0);
    void'(exp_q.pop_front());
    drive(0, 0, 0, 1, 2, 13, 0);
    void'(exp_q.pop_front());
    total++;
    if (disp_hours !== 5'd13 || pm !== 1'b0) begin
      bad++; $display("FAIL disp24_h13: got disp=%0d pm=%b want disp=13 pm=0", disp_hours, pm);
    end
  endtask

  task automatic test_alarm();
    snap_t e, a;
    // cols: kind (0 load, 1 tick, 2 idle, 3 ack), addr, data
    int tbl[11][3] = '{'{0, 4, 30}, '{0, 5, 7}, '{0, 2, 7}, '{0, 1, 29},
                       '{0, 0, 59}, '{1, 0, 0}, '{2, 0, 0}, '{3, 0, 0},
                       '{0, 4, 60}, '{0, 0, 0}, '{0, 5, 24}};
    for (int i = 0; i < 11; i++) begin
      case (tbl[i][0])
        0: drive(0, 0, 0, 1, tbl[i][1], tbl[i][2], 0);
        1: drive(0, 1, 0, 0, 0, 0, 0);
        2: drive(0, 0, 0, 0, 0, 0, 0);
        default: drive(0, 0, 0, 0, 0, 0, 1);
      endcase
      e = exp_q.pop_front(); a = observe(); total++;
      if (a !== e) begin bad++; $display("FAIL alarm_step%0d: got %s want %s", i, fmt(a), fmt(e)); end
    end
    // set and ack in the same cycle: set wins
    drive(0, 0, 0, 1, 0, 59, 0);
    void'(exp_q.pop_front());
    drive(0, 0, 0, 1, 1, 29, 0);
    void'(exp_q.pop_front());
    drive(0, 1, 0, 0, 0, 0, 1);
    e = exp_q.pop_front(); a = observe(); total++;
    if (a !== e) begin bad++; $display("FAIL alarm_set_vs_ack: got %s want %s", fmt(a), fmt(e)); end
    drive(0, 0, 0, 1, 3, 0, 0);
    e = exp_q.pop_front(); a = observe(); total++;
    if (a !== e) begin bad++; $display("FAIL alarm_ctrl_clear: got %s want %s", fmt(a), fmt(e)); end
  endtask

  task automatic test_reset_mid();
    snap_t e, a;
    drive(0, 1, 0, 0, 0, 0, 0);
    void'(exp_q.pop_front());
    drive(1, 1, 0, 0, 0, 0, 0);
    e = exp_q.pop_front(); a = observe(); total++;
    if (a !== e) begin bad++; $display("FAIL reset_mid: got %s want %s", fmt(a), fmt(e)); end
    drive(0, 1, 0, 0, 0, 0, 0);
    e = exp_q.pop_front(); a = observe(); total++;
    if (a !== e) begin bad++; $display("FAIL first_tick_after_reset: got %s want %s", fmt(a), fmt(e)); end
  endtask

  initial begin
    reset = 1; tc_time_base = 0; hold = 0; load = 0;
    addrs = 0; data_in = 0; alarm_ack = 0;
    void'(mdl_reset());
    @(posedge clk); #1;
    test_reset();
    test_minute();
    test_midnight();
    test_load_err();
    test_load_tick_hold();
    test_back_to_back();
    test_12h();
    test_alarm();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
